// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the fifo_arb write arbiter / read scheduler.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int DEFAULT_W     = 8;
    localparam int DEFAULT_DEPTH = 16;

    // Occupancy counter must be able to hold DEPTH itself, hence the extra bit.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int wrap_inc(input int base, input int step, input int n);
        return (base + step) % n;
    endfunction

endpackage

// File: rtl/fifo_arb_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the pointer.
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic            enable,
    input  logic [PW-1:0]   pointer,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   winner
);

    logic found;

    always_comb begin
        gnt    = '0;
        winner = '0;
        found  = 1'b0;
        if (enable) begin
            for (int i = 1; i <= NREQ; i++) begin
                if (!found && req[wrap_inc(int'(pointer), i, NREQ)]) begin
                    found = 1'b1;
                    gnt[wrap_inc(int'(pointer), i, NREQ)] = 1'b1;
                    winner = PW'(wrap_inc(int'(pointer), i, NREQ));
                end
            end
        end
    end

endmodule

// File: rtl/fifo_arb.sv
// Round-robin write arbiter, read scheduler and flush sequencer for the 8-bit fifo.
// Optional build macro FIFO_ARB_WATERMARK_EN: restrict grants to producer 0 while FIFO_PFF.
module fifo_arb
    import fifo_arb_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int W     = DEFAULT_W,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                          clk,
    input  logic                          RESET_N,
    input  logic [NREQ-1:0]               WREQ,
    input  logic [NREQ*W-1:0]             WDATA,
    output logic [NREQ-1:0]               WGNT,
    input  logic                          RD_REQ,
    output logic                          RD_GNT,
    output logic [W-1:0]                  RD_DATA,
    output logic                          RD_VALID,
    input  logic                          FLUSH,
    output logic                          BUSY,
    output logic [level_width(DEPTH)-1:0] LEVEL,
    output logic [W-1:0]                  FIFO_DIN,
    output logic                          FIFO_WE,
    output logic                          FIFO_RE,
    output logic                          FIFO_RST,
    input  logic [W-1:0]                  FIFO_DOUT,
    input  logic                          FIFO_EF,
    input  logic                          FIFO_PEF,
    input  logic                          FIFO_FF,
    input  logic                          FIFO_PFF
);

    localparam int PW = $clog2(NREQ);
    localparam int LW = level_width(DEPTH);

    state_t          state_reg;
    logic [PW-1:0]   last_reg;
    logic [LW-1:0]   level_reg;
    logic            rd_valid_reg;

    logic            in_run;
    logic            wr_enable;
    logic            wr_fire;
    logic            rd_fire;
    logic [NREQ-1:0] req_eligible;
    logic [NREQ-1:0] gnt;
    logic [PW-1:0]   winner;
    logic [W-1:0]    din_slice [NREQ];
    logic [W-1:0]    din_merged;
    logic            unused_flags;

    // Gating with RESET_N forces the combinational outputs quiet while in reset.
    assign in_run = RESET_N && (state_reg == ST_RUN);

`ifdef FIFO_ARB_WATERMARK_EN
    assign req_eligible = FIFO_PFF ? (WREQ & NREQ'(1)) : WREQ;
`else
    assign req_eligible = WREQ;
`endif
    assign unused_flags = ^{FIFO_PEF, FIFO_PFF};

    assign wr_enable = in_run && !FIFO_FF;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_arbiter (
        .req     (req_eligible),
        .enable  (wr_enable),
        .pointer (last_reg),
        .gnt     (gnt),
        .winner  (winner)
    );

    // One-hot grant lets the data mux be a plain AND-OR.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_din
            assign din_slice[gi] = gnt[gi] ? WDATA[gi*W +: W] : '0;
        end
    endgenerate

    always_comb begin
        din_merged = '0;
        for (int i = 0; i < NREQ; i++) begin
            din_merged = din_merged | din_slice[i];
        end
    end

    assign wr_fire  = |gnt;
    assign rd_fire  = in_run && RD_REQ && !FIFO_EF;

    assign WGNT     = gnt;
    assign FIFO_WE  = wr_fire;
    assign FIFO_DIN = din_merged;
    assign RD_GNT   = rd_fire;
    assign FIFO_RE  = rd_fire;
    assign RD_VALID = rd_valid_reg;
    assign RD_DATA  = rd_valid_reg ? FIFO_DOUT : '0;
    assign FIFO_RST = !RESET_N || (state_reg == ST_FLUSH);
    assign BUSY     = (state_reg != ST_RUN);
    assign LEVEL    = level_reg;

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg    <= ST_RUN;
            last_reg     <= PW'(NREQ - 1);
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= rd_fire;
            if (wr_fire) begin
                last_reg <= winner;
            end
            case (state_reg)
                ST_RUN:   if (FLUSH) state_reg <= ST_FLUSH;
                ST_FLUSH: state_reg <= ST_DRAIN;
                ST_DRAIN: if (FIFO_EF) state_reg <= ST_RUN;
                default:  state_reg <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            level_reg <= '0;
        end else if (state_reg == ST_FLUSH) begin
            level_reg <= '0;
        end else begin
            case ({wr_fire, rd_fire})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: doc/fifo_arb.md
# fifo_arb

Write arbiter and read scheduler sitting in front of the 8-bit `fifo`. It shares the FIFO's single write port between NREQ producers with round-robin arbitration and gates the producers on the FIFO full flags. It issues consumer reads gated on the empty flag and presents returned data with a valid strobe. It also sequences a flush of the FIFO through its RESET input and tracks occupancy.

## Interface
- NREQ, 2: number of write requesters (2..4)
- W, 8: data width, matches FIFO
- DEPTH, 16: FIFO depth; LEVEL width is $clog2(DEPTH)+1
- clk  in  1  system clock, posedge
- RESET_N  in  1  asynchronous, active-low reset
- WREQ  in  NREQ  per-producer write request; data is consumed in the cycle WGNT is high
- WDATA  in  NREQ*W  producer data, slice i = WDATA[i*W +: W]
- WGNT  out  NREQ  one-hot write grant, combinational
- RD_REQ  in  1  consumer read request
- RD_GNT  out  1  read accepted this cycle, combinational
- RD_DATA  out  W  read data; 0 when RD_VALID is low
- RD_VALID  out  1  RD_DATA valid; one cycle after RD_GNT
- FLUSH  in  1  single-cycle flush request
- BUSY  out  1  flush in progress
- LEVEL  out  $clog2(DEPTH)+1  occupancy count
- FIFO_DIN  out  W;  FIFO_WE  out  1;  FIFO_RE  out  1;  FIFO_RST  out  1 (active-high)
- FIFO_DOUT  in  W;  FIFO_EF, FIFO_PEF, FIFO_FF, FIFO_PFF  in  1 each

## Operation
- State machine:
  - RUN: normal operation.
  - FLUSH: one cycle; drives FIFO_RST=1.
  - DRAIN: waits for FIFO_EF=1, then returns to RUN.
  - FLUSH sampled high in RUN moves to FLUSH. FLUSH is ignored in FLUSH and DRAIN.
- Write eligibility: state==RUN and FIFO_FF==0.
- Write arbitration: round-robin pointer LAST. Search starts at (LAST+1) mod NREQ. The first asserted WREQ wins WGNT.
  - FIFO_WE = |WGNT.
  - FIFO_DIN = WDATA slice of the winner, else 0.
  - LAST updates to the winner on a grant edge and holds otherwise.
- Read: RD_GNT = FIFO_RE = RD_REQ & ~FIFO_EF & (state==RUN).
  - RD_VALID is the registered RD_GNT.
  - RD_DATA = RD_VALID ? FIFO_DOUT : 0.
- LEVEL: +1 on a write-only edge, -1 on a read-only edge, unchanged when both or neither occur. Cleared in the FLUSH state.
- Simultaneous write and read:
  - Both are allowed when neither flag blocks.
  - On an empty FIFO only the write proceeds.
  - On a full FIFO only the read proceeds.
- FIFO_RST = ~RESET_N | (state==FLUSH).
- BUSY = state != RUN.

## Timing
- Reset values (RESET_N low, asynchronous):
  - state=RUN, LAST=NREQ-1 (producer 0 wins first), LEVEL=0, RD_VALID=0.
  - WGNT=0, RD_GNT=0, FIFO_WE=0, FIFO_RE=0, RD_DATA=0, FIFO_RST=1, BUSY=0.
  - Combinational outputs are forced to these values while reset is low.
- Write latency 0: the grant and FIFO write occur on the same posedge the request is seen.
- Read latency 1: data on RD_DATA in the cycle after RD_GNT.
- FIFO_FF and FIFO_EF are used as sampled in the current cycle. No write is issued to a full FIFO, and no read to an empty one.
- LAST wraps NREQ-1 → 0.
- Flush timing: FLUSH high at edge N gives FIFO_RST high in cycle N+1, then DRAIN until EF is seen, then RUN. No grants are issued in FLUSH or DRAIN.
- A read issued in the cycle before FLUSH still returns RD_VALID in the following cycle.
- Reset mid-flush returns the block to RUN with the reset values above.

## Configuration
- FIFO_ARB_WATERMARK_EN defined: while FIFO_PFF=1, only producer 0 is eligible for grants. Other requests wait and LAST is not advanced by them.
- FIFO_ARB_WATERMARK_EN undefined: FIFO_PFF is ignored and all producers arbitrate until FIFO_FF.
- FIFO_PEF is unused in both builds.

## Structure
- Shared package fifo_arb_pkg holds:
  - the state encoding (ST_RUN=2'd0, ST_FLUSH=2'd1, ST_DRAIN=2'd2)
  - default W and DEPTH constants
  - the LEVEL width function.
- One sub-module, rr_arbiter: NREQ-wide round-robin arbiter with inputs req, enable and pointer, and outputs one-hot gnt and winner index.

## Test plan
- Reset, then WREQ=2'b11 held with FIFO not full → WGNT alternates 01,10,01,…; LEVEL increments once per cycle.
- Fill to FIFO_FF=1 with WREQ held → WGNT=0, FIFO_WE=0, LEVEL=16. Then RD_REQ=1 → a read each cycle and a write is re-granted once FF drops.
- Empty FIFO with RD_REQ=1 and WREQ[0]=1 → write is granted and RD_GNT=0. In the next cycle RD_GNT=1, and RD_VALID=1 one cycle later with RD_DATA equal to the written byte.
- LEVEL=5, pulse FLUSH → BUSY=1, FIFO_RST high for exactly one cycle, LEVEL=0, no grants until EF=1, then BUSY=0.
- With FIFO_ARB_WATERMARK_EN defined, FIFO_PFF=1 and WREQ=2'b11 → only WGNT=01. After PFF falls, alternation resumes.
- Assert RESET_N low during DRAIN → all outputs take their reset values immediately. After release, producer 0 is granted first.
